// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester-side and SPI-master-side signal bundle for spi_arbiter
//
// Purpose : groups every non-clock/reset signal of spi_arbiter into one bundle.
// Ports   : req/req_op/req_slave/req_wdata  requester requests (slice i belongs to requester i)
//           grant/done/rdata/err/busy       arbitration results back to the requesters
//           spi_start/spi_operation/spi_slave/spi_outgoing  command to the shared SPI master
//           spi_eot/spi_incoming            completion and read byte from the SPI master
// Modports: master = arbiter side, slave = requesters plus SPI master side.
interface spi_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_op;
  logic [2*N_REQ-1:0]  req_slave;
  logic [16*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [7:0]          rdata;
  logic                err;
  logic                busy;
  logic                spi_start;
  logic                spi_operation;
  logic [1:0]          spi_slave;
  logic [15:0]         spi_outgoing;
  logic                spi_eot;
  logic [7:0]          spi_incoming;

  modport master (
    input  req, req_op, req_slave, req_wdata, spi_eot, spi_incoming,
    output grant, done, rdata, err, busy,
           spi_start, spi_operation, spi_slave, spi_outgoing
  );

  modport slave (
    output req, req_op, req_slave, req_wdata, spi_eot, spi_incoming,
    input  grant, done, rdata, err, busy,
           spi_start, spi_operation, spi_slave, spi_outgoing
  );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master among N_REQ requesters
//
// Purpose : grants the SPI master to one requester at a time (round-robin after the
//           last owner), issues a one-cycle start, waits for end-of-transaction,
//           captures read data and pulses done to the owner.
// Ports   : clk    system clock, rising edge
//           rst_n  synchronous active-low reset
//           bus    spi_arbiter_if.master (requests, grant/done/rdata/err/busy, SPI command)
// Params  : N_REQ (2..8), TIMEOUT_CYCLES (WAIT watchdog length)
// Macro   : SPI_ARB_TIMEOUT_EN - builds the WAIT watchdog; undefined means WAIT lasts
//           until spi_eot and err is tied low.
module spi_arbiter #(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_arbiter_if.master  bus
);
  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("spi_arbiter: N_REQ must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    last_ptr_q;
  logic [PW-1:0]    owner_q;
  logic [N_REQ-1:0] grant_q;
  logic             op_q;
  logic [1:0]       slave_q;
  logic [15:0]      out_q;
  logic [7:0]       rdata_q;
  logic             timeout;
  logic             spi_start_c;
  logic             busy_c;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  // Scan upward from the slot after the last owner, wrapping at N_REQ; the first
  // requesting slot wins, so the last owner is always considered last.
  always_comb begin
    int idx;
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_valid && bus.req[idx]) begin
        pick_valid       = 1'b1;
        pick_idx         = PW'(idx);
        pick_onehot[idx] = 1'b1;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt_q;
  logic          err_q;

  // Held at zero outside WAIT, so it restarts on every WAIT entry; the timeout fires
  // in the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + CW'(1) : '0;
      if (state_q == S_WAIT) err_q <= timeout;
    end
  end

  assign timeout = (state_q == S_WAIT) && !bus.spi_eot &&
                   (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus.err = (state_q == S_DONE) && err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_ptr_q <= PW'(N_REQ - 1);
      owner_q    <= '0;
      grant_q    <= '0;
      op_q       <= 1'b0;
      slave_q    <= '0;
      out_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= pick_onehot;
            op_q    <= bus.req_op[pick_idx];
            slave_q <= bus.req_slave[2*pick_idx +: 2];
            out_q   <= bus.req_wdata[16*pick_idx +: 16];
          end
        end
        S_WAIT: begin
          // Writes leave rdata untouched so a requester can still read the last byte.
          if (bus.spi_eot && !op_q) rdata_q <= bus.spi_incoming;
        end
        S_DONE: begin
          last_ptr_q <= owner_q;
          grant_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    spi_start_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (pick_valid) state_d = S_START;
      end
      S_START: begin
        spi_start_c = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.spi_eot || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // grant stays up through DONE so done can be derived from it for that one cycle.
  assign bus.grant         = grant_q;
  assign bus.done          = (state_q == S_DONE) ? grant_q : '0;
  assign bus.rdata         = rdata_q;
  assign bus.busy          = busy_c;
  assign bus.spi_start     = spi_start_c;
  assign bus.spi_operation = op_q;
  assign bus.spi_slave     = slave_q;
  assign bus.spi_outgoing  = out_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter (vector table plus corner sequences)
module tb_spi_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_arbiter_if #(.N_REQ(N)) bus ();

  spi_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        pre_reset;
    logic [2:0]  req;
    logic [2:0]  op;
    logic [5:0]  slave;
    logic [47:0] wdata;
    int          eot_delay;
    logic [7:0]  incoming;
    logic [2:0]  release_mask;
    logic [2:0]  exp_grant;
    logic        exp_op;
    logic [1:0]  exp_slave;
    logic [15:0] exp_out;
    logic [7:0]  exp_rdata;
  } vec_t;

  // Requester configurations: slice i belongs to requester i.
  localparam logic [2:0]  OP_A    = 3'b010;
  localparam logic [5:0]  SLV_A   = {2'b11, 2'b01, 2'b10};
  localparam logic [47:0] WD_A    = {16'hC3C3, 16'h1A6A, 16'h5555};
  localparam logic [2:0]  OP_B    = 3'b101;
  localparam logic [5:0]  SLV_B   = {2'b00, 2'b11, 2'b01};
  localparam logic [47:0] WD_B    = {16'hBEEF, 16'h0F0F, 16'h1234};

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " grant"},     bus.grant, 0);
    check({tag, " done"},      bus.done, 0);
    check({tag, " err"},       bus.err, 0);
    check({tag, " busy"},      bus.busy, 0);
    check({tag, " spi_start"}, bus.spi_start, 0);
    check({tag, " spi_op"},    bus.spi_operation, 0);
    check({tag, " spi_slave"}, bus.spi_slave, 0);
    check({tag, " spi_out"},   bus.spi_outgoing, 0);
    check({tag, " rdata"},     bus.rdata, 0);
  endtask

  // Returns at the negedge in START (grant visible), or after a bounded wait.
  task automatic await_grant(input string tag, input logic [2:0] exp);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == '0 && cyc < 10);
    check({tag, " grant"}, bus.grant, exp);
    check({tag, " spi_start"}, bus.spi_start, 1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bus.req       = v.req;
    bus.req_op    = v.op;
    bus.req_slave = v.slave;
    bus.req_wdata = v.wdata;
    await_grant(tag, v.exp_grant);
    check({tag, " spi_op"},    bus.spi_operation, v.exp_op);
    check({tag, " spi_slave"}, bus.spi_slave, v.exp_slave);
    check({tag, " spi_out"},   bus.spi_outgoing, v.exp_out);
    check({tag, " busy"},      bus.busy, 1);
    @(negedge clk);
    check({tag, " start one cycle"}, bus.spi_start, 0);
    for (int i = 0; i < v.eot_delay; i++) begin
      @(negedge clk);
      check({tag, " early done"}, bus.done, 0);
    end
    bus.spi_eot      = 1'b1;
    bus.spi_incoming = v.incoming;
    @(negedge clk);
    bus.spi_eot      = 1'b0;
    bus.spi_incoming = 8'h00;
    check({tag, " done"},  bus.done, v.exp_grant);
    check({tag, " rdata"}, bus.rdata, v.exp_rdata);
    check({tag, " err"},   bus.err, 0);
    bus.req = bus.req & ~v.release_mask;
    @(negedge clk);
    check({tag, " idle done"},  bus.done, 0);
    check({tag, " idle grant"}, bus.grant, 0);
    check({tag, " idle busy"},  bus.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t h;
    vecs[0] = '{1'b0, 3'b010, OP_A, SLV_A, WD_A, 1, 8'hEE, 3'b010, 3'b010, 1'b1, 2'b01, 16'h1A6A, 8'h00};
    vecs[1] = '{1'b0, 3'b001, OP_A, SLV_A, WD_A, 0, 8'h95, 3'b001, 3'b001, 1'b0, 2'b10, 16'h5555, 8'h95};
    vecs[2] = '{1'b1, 3'b111, OP_B, SLV_B, WD_B, 2, 8'h11, 3'b000, 3'b001, 1'b1, 2'b01, 16'h1234, 8'h00};
    vecs[3] = '{1'b0, 3'b111, OP_B, SLV_B, WD_B, 0, 8'h22, 3'b000, 3'b010, 1'b0, 2'b11, 16'h0F0F, 8'h22};
    vecs[4] = '{1'b0, 3'b111, OP_B, SLV_B, WD_B, 1, 8'h33, 3'b000, 3'b100, 1'b1, 2'b00, 16'hBEEF, 8'h22};
    vecs[5] = '{1'b0, 3'b111, OP_B, SLV_B, WD_B, 0, 8'h44, 3'b000, 3'b001, 1'b1, 2'b01, 16'h1234, 8'h22};
    vecs[6] = '{1'b0, 3'b111, OP_B, SLV_B, WD_B, 3, 8'h5A, 3'b000, 3'b010, 1'b0, 2'b11, 16'h0F0F, 8'h5A};
    vecs[7] = '{1'b0, 3'b111, OP_B, SLV_B, WD_B, 0, 8'h66, 3'b111, 3'b100, 1'b1, 2'b00, 16'hBEEF, 8'h5A};

    rst_n            = 1'b0;
    bus.req          = '0;
    bus.req_op       = '0;
    bus.req_slave    = '0;
    bus.req_wdata    = '0;
    bus.spi_eot      = 1'b0;
    bus.spi_incoming = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_reset) begin
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // spi_eot in IDLE is ignored
    bus.spi_eot      = 1'b1;
    bus.spi_incoming = 8'h77;
    @(negedge clk);
    bus.spi_eot      = 1'b0;
    check("idle eot busy",  bus.busy, 0);
    check("idle eot done",  bus.done, 0);
    check("idle eot rdata", bus.rdata, 8'h5A);

    // spi_eot during START is ignored; WAIT still needs its own eot
    bus.req = 3'b010;
    await_grant("start eot", 3'b010);
    bus.spi_eot      = 1'b1;
    bus.spi_incoming = 8'h77;
    @(negedge clk);
    bus.spi_eot = 1'b0;
    check("start eot wait1 done", bus.done, 0);
    @(negedge clk);
    check("start eot wait2 done", bus.done, 0);
    check("start eot wait2 busy", bus.busy, 1);
    bus.spi_eot      = 1'b1;
    bus.spi_incoming = 8'h3C;
    @(negedge clk);
    bus.spi_eot = 1'b0;
    check("start eot done",  bus.done, 3'b010);
    check("start eot rdata", bus.rdata, 8'h3C);
    bus.req = '0;
    @(negedge clk);

    // Abandoned request: req[2] drops in WAIT, transaction still completes
    bus.req = 3'b100;
    await_grant("abandon", 3'b100);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    bus.spi_eot      = 1'b1;
    bus.spi_incoming = 8'h99;
    @(negedge clk);
    bus.spi_eot = 1'b0;
    check("abandon done",  bus.done, 3'b100);
    check("abandon rdata", bus.rdata, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abandon no regrant %0d", i), bus.grant, 0);
    end

    // Reset mid-WAIT
    bus.req = 3'b010;
    await_grant("rst wait", 3'b010);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_reset_state("rst wait");
    rst_n = 1'b1;
    h = '{1'b0, 3'b001, OP_B, SLV_B, WD_B, 0, 8'hAB, 3'b001, 3'b001, 1'b1, 2'b01, 16'h1234, 8'h00};
    run_txn(h, "after rst");

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int waits;
      bus.req = 3'b001;
      await_grant("timeout", 3'b001);
      waits = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done != '0) break;
        waits++;
      end
      check("timeout wait cycles", waits, 16);
      check("timeout done",  bus.done, 3'b001);
      check("timeout err",   bus.err, 1);
      check("timeout rdata", bus.rdata, 8'h00);
      bus.req = '0;
      @(negedge clk);
      check("timeout idle busy", bus.busy, 0);
      check("timeout idle err",  bus.err, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
